// File: rtl/riscv_soft_fetch_unit_if.sv
// rtl/riscv_soft_fetch_unit_if.sv - I-cache request/response and instruction stream bundle
interface riscv_soft_fetch_unit_if #(
    parameter int XPR_LEN = 32
);
    logic               i_cache_req_valid;
    logic               i_cache_req_ready;
    logic [XPR_LEN-1:0] i_cache_req_addr;
    logic               i_cache_resp_valid;
    logic [31:0]        i_cache_resp_data;
    logic               inst_valid;
    logic               inst_ready;
    logic [31:0]        inst_data;
    logic [XPR_LEN-1:0] inst_PC;
    logic [XPR_LEN-1:0] inst_PC_plus_4;

    modport master (
        output i_cache_req_valid, i_cache_req_addr,
        input  i_cache_req_ready,
        input  i_cache_resp_valid, i_cache_resp_data,
        output inst_valid, inst_data, inst_PC, inst_PC_plus_4,
        input  inst_ready
    );

    modport slave (
        input  i_cache_req_valid, i_cache_req_addr,
        output i_cache_req_ready,
        output i_cache_resp_valid, i_cache_resp_data,
        input  inst_valid, inst_data, inst_PC, inst_PC_plus_4,
        output inst_ready
    );
endinterface

// File: rtl/riscv_soft_fetch_unit.sv
// rtl/riscv_soft_fetch_unit.sv - credit-limited instruction fetch unit with redirect flush
module riscv_soft_fetch_unit #(
    parameter int                 XPR_LEN  = 32,
    parameter int                 FQ_DEPTH = 4,
    parameter logic [XPR_LEN-1:0] RESET_PC = 'h200
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      redirect_valid,
    input  logic [XPR_LEN-1:0]        redirect_PC,
    riscv_soft_fetch_unit_if.master   bus
);
    localparam int PW = $clog2(FQ_DEPTH);
    localparam int CW = PW + 1;

    logic [XPR_LEN-1:0] fetch_pc;
    logic [XPR_LEN-1:0] resp_pc;
    logic [CW-1:0]      outstanding;
    logic [CW-1:0]      outstanding_next;
    logic [CW-1:0]      discard;
    logic [CW-1:0]      count;
    logic [PW-1:0]      rd_ptr;
    logic [PW-1:0]      wr_ptr;
    logic [CW:0]        in_use;
    logic [XPR_LEN-1:0] pc_mem   [FQ_DEPTH];
    logic [31:0]        data_mem [FQ_DEPTH];
    logic [XPR_LEN-1:0] redirect_target;

    logic req_fire;
    logic push;
    logic pop;

    // Every request in flight reserves a queue slot, so a response can never find the queue full.
    assign in_use = {1'b0, outstanding} + {1'b0, count};

    assign bus.i_cache_req_valid = !reset && !redirect_valid && (in_use < (CW+1)'(FQ_DEPTH));
    assign bus.i_cache_req_addr  = fetch_pc;
    assign bus.inst_valid        = !reset && (count != '0);
    assign bus.inst_data         = data_mem[rd_ptr];
    assign bus.inst_PC           = pc_mem[rd_ptr];
    assign bus.inst_PC_plus_4    = pc_mem[rd_ptr] + XPR_LEN'(4);

    assign redirect_target = {redirect_PC[XPR_LEN-1:2], 2'b00};
    assign req_fire        = bus.i_cache_req_valid && bus.i_cache_req_ready;
    assign push            = bus.i_cache_resp_valid && (discard == '0) && !redirect_valid;
    assign pop             = bus.inst_valid && bus.inst_ready && !redirect_valid;

    always_comb begin
        outstanding_next = outstanding;
        if (req_fire)
            outstanding_next = outstanding_next + CW'(1);
        if (bus.i_cache_resp_valid)
            outstanding_next = outstanding_next - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else begin
            outstanding <= outstanding_next;
            if (redirect_valid) begin
                // Everything still in flight after this cycle belongs to the old path.
                fetch_pc <= redirect_target;
                resp_pc  <= redirect_target;
                discard  <= outstanding_next;
                count    <= '0;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
            end else begin
                if (req_fire)
                    fetch_pc <= fetch_pc + XPR_LEN'(4);
                if (bus.i_cache_resp_valid && (discard != '0))
                    discard <= discard - CW'(1);
                if (push) begin
                    resp_pc <= resp_pc + XPR_LEN'(4);
                    wr_ptr  <= wr_ptr + PW'(1);
                end
                if (pop)
                    rd_ptr <= rd_ptr + PW'(1);
                case ({push, pop})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && push) begin
            pc_mem[wr_ptr]   <= resp_pc;
            data_mem[wr_ptr] <= bus.i_cache_resp_data;
        end
    end
endmodule

// File: tb/tb_riscv_soft_fetch_unit.sv
// tb/tb_riscv_soft_fetch_unit.sv - self-checking bench for riscv_soft_fetch_unit
module tb_riscv_soft_fetch_unit;
    localparam int          XL   = 32;
    localparam int          D    = 4;
    localparam logic [31:0] RPC  = 32'h0000_0200;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_PC = '0;

    riscv_soft_fetch_unit_if #(.XPR_LEN(XL)) bus ();

    riscv_soft_fetch_unit #(.XPR_LEN(XL), .FQ_DEPTH(D), .RESET_PC(RPC)) dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_PC    (redirect_PC),
        .bus            (bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    typedef struct { logic [31:0] addr; logic [31:0] pc; int epoch; int due; } req_t;
    typedef struct { logic [31:0] pc; logic [31:0] data; } ent_t;

    req_t        pend[$];
    ent_t        mq[$];
    int          epoch = 0;
    int          cyc = 0;
    int          lat = 1;
    int          acc_count = 0;
    int          drop_count = 0;
    logic [31:0] exp_fetch = RPC;

    function automatic logic [31:0] mem_word(logic [31:0] a);
        return a ^ 32'hDEAD_BEEF;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // I-cache: in-order responses, each no earlier than its due cycle.
    always @(posedge clk) begin
        #1;
        if (!reset && pend.size() > 0 && pend[0].due <= cyc) begin
            bus.i_cache_resp_valid = 1'b1;
            bus.i_cache_resp_data  = mem_word(pend[0].addr);
        end else begin
            bus.i_cache_resp_valid = 1'b0;
            bus.i_cache_resp_data  = '0;
        end
    end

    // Reference model: path epochs decide which responses survive; queue holds {pc,data}.
    always @(negedge clk) begin
        bit   exp_rv;
        bit   exp_iv;
        req_t r;
        exp_rv = !reset && !redirect_valid && ((pend.size() + mq.size()) < D);
        exp_iv = !reset && (mq.size() != 0);
        chk("req_valid", bus.i_cache_req_valid, exp_rv);
        if (exp_rv)
            chk("req_addr", bus.i_cache_req_addr, exp_fetch);
        chk("inst_valid", bus.inst_valid, exp_iv);
        if (exp_iv) begin
            chk("inst_PC", bus.inst_PC, mq[0].pc);
            chk("inst_data", bus.inst_data, mq[0].data);
            chk("inst_PC_plus_4", bus.inst_PC_plus_4, mq[0].pc + 32'd4);
        end

        if (reset) begin
            pend.delete();
            mq.delete();
            epoch++;
            exp_fetch = RPC;
        end else begin
            if (!redirect_valid && bus.inst_valid && bus.inst_ready && mq.size() != 0)
                void'(mq.pop_front());
            if (bus.i_cache_resp_valid) begin
                if (pend.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL resp_without_outstanding: got response expected none");
                end else begin
                    r = pend.pop_front();
                    if (!redirect_valid && r.epoch == epoch)
                        mq.push_back('{pc: r.pc, data: mem_word(r.addr)});
                    else
                        drop_count++;
                end
            end
            if (redirect_valid) begin
                mq.delete();
                epoch++;
                exp_fetch = {redirect_PC[31:2], 2'b00};
            end else if (bus.i_cache_req_valid && bus.i_cache_req_ready) begin
                pend.push_back('{addr: bus.i_cache_req_addr, pc: exp_fetch, epoch: epoch, due: cyc + lat});
                exp_fetch = exp_fetch + 32'd4;
                acc_count++;
            end
        end
        cyc++;
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_inst(string nm, int max);
        int n = 0;
        @(negedge clk);
        while (!bus.inst_valid && n < max) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (!bus.inst_valid) begin
            fails++;
            $display("FAIL %s: got no inst_valid expected one within %0d cycles", nm, max);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish expected end of run");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.i_cache_req_ready  = 1'b1;
        bus.inst_ready         = 1'b1;
        bus.i_cache_resp_valid = 1'b0;
        bus.i_cache_resp_data  = '0;

        // Reset state and first request.
        repeat (3) step();
        @(negedge clk);
        chk("rst_req_valid", bus.i_cache_req_valid, 0);
        chk("rst_inst_valid", bus.inst_valid, 0);
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("first_req_valid", bus.i_cache_req_valid, 1);
        chk("first_req_addr", bus.i_cache_req_addr, 32'h0000_0200);

        // Streaming, one instruction per cycle.
        wait_inst("fill_timeout", 10);
        chk("first_inst_PC", bus.inst_PC, 32'h0000_0200);
        chk("first_inst_data", bus.inst_data, 32'hDEAD_BCEF);
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            chk("stream_PC", bus.inst_PC, 32'h200 + 32'(4 * i));
        end
        repeat (15) step();

        // Consumer stall: credits cap requests at queue depth.
        redirect_valid = 1'b1;
        redirect_PC    = 32'h0000_3000;
        bus.inst_ready = 1'b0;
        acc_count      = 0;
        step();
        redirect_valid = 1'b0;
        repeat (10) step();
        @(negedge clk);
        chk("stall_accepts", acc_count, 4);
        chk("stall_req_valid", bus.i_cache_req_valid, 0);
        chk("stall_model_count", mq.size(), 4);
        chk("stall_head_PC", bus.inst_PC, 32'h0000_3000);
        step();
        bus.inst_ready = 1'b1;
        repeat (20) step();

        // Redirect with three requests in flight.
        bus.i_cache_req_ready = 1'b0;
        repeat (8) step();
        lat = 10;
        bus.i_cache_req_ready = 1'b1;
        repeat (3) step();
        redirect_valid = 1'b1;
        redirect_PC    = 32'h0000_1002;
        lat            = 1;
        drop_count     = 0;
        step();
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("redir_req_addr", bus.i_cache_req_addr, 32'h0000_1000);
        wait_inst("redir_timeout", 40);
        chk("redir_inst_PC", bus.inst_PC, 32'h0000_1000);
        chk("redir_dropped", drop_count, 3);
        repeat (10) step();

        // Redirect coinciding with a response and a pop, two entries queued.
        bus.i_cache_req_ready = 1'b0;
        repeat (8) step();
        bus.i_cache_req_ready = 1'b1;
        bus.inst_ready = 1'b0;
        begin
            int n = 0;
            step();
            while (!(mq.size() == 2 && bus.i_cache_resp_valid) && n < 30) begin
                step();
                n++;
            end
            chk("coincide_setup", (mq.size() == 2 && bus.i_cache_resp_valid), 1);
        end
        redirect_valid = 1'b1;
        redirect_PC    = 32'h0000_2000;
        bus.inst_ready = 1'b1;
        step();
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("coincide_flushed", bus.inst_valid, 0);
        wait_inst("coincide_timeout", 20);
        chk("coincide_inst_PC", bus.inst_PC, 32'h0000_2000);
        repeat (5) step();

        // Address wrap.
        redirect_valid = 1'b1;
        redirect_PC    = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("wrap_addr0", bus.i_cache_req_addr, 32'hFFFF_FFFC);
        @(negedge clk);
        chk("wrap_addr1", bus.i_cache_req_addr, 32'h0000_0000);
        wait_inst("wrap_timeout", 10);
        chk("wrap_inst_PC", bus.inst_PC, 32'hFFFF_FFFC);
        chk("wrap_plus4", bus.inst_PC_plus_4, 32'h0000_0000);
        repeat (5) step();

        // Request held while the I-cache is not ready.
        redirect_valid = 1'b1;
        redirect_PC    = 32'h0000_5000;
        bus.i_cache_req_ready = 1'b0;
        step();
        redirect_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_valid", bus.i_cache_req_valid, 1);
            chk("hold_addr", bus.i_cache_req_addr, 32'h0000_5000);
        end
        step();
        bus.i_cache_req_ready = 1'b1;
        repeat (4) step();

        // Reset mid-stream.
        reset = 1'b1;
        step();
        @(negedge clk);
        chk("midrst_req_valid", bus.i_cache_req_valid, 0);
        chk("midrst_inst_valid", bus.inst_valid, 0);
        step();
        reset = 1'b0;
        wait_inst("postrst_timeout", 10);
        chk("postrst_inst_PC", bus.inst_PC, 32'h0000_0200);
        repeat (10) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
